// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encodings, halt opcode, counter width.
// Optional feature macro: SINGLE_STEP_EN adds the STEP_WAIT state.
package fetch_pkg;

  localparam int          FETCH_CNT_W    = 16;
  localparam logic [7:0]  HALT_INSTR_DEF = 8'h30;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_CAPTURE   = 3'd2;
  localparam logic [2:0] ST_PRESENT   = 3'd3;
  localparam logic [2:0] ST_HALTED    = 3'd4;
  localparam logic [2:0] ST_STEP_WAIT = 3'd5;

`ifdef SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_ISSUE     = ST_ISSUE,
    S_CAPTURE   = ST_CAPTURE,
    S_PRESENT   = ST_PRESENT,
    S_HALTED    = ST_HALTED,
    S_STEP_WAIT = ST_STEP_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_CAPTURE = ST_CAPTURE,
    S_PRESENT = ST_PRESENT,
    S_HALTED  = ST_HALTED
  } state_t;
`endif

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory, decode and execute.
// master = sequencer side, slave = the surrounding memory/decode/execute side.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  import fetch_pkg::*;

  logic                   start;
  logic [ADDR_W-1:0]      imem_addr;
  logic                   imem_en;
  logic [INSTR_W-1:0]     imem_data;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_W-1:0]     instr_out;
  logic [ADDR_W-1:0]      instr_pc;
  logic                   redirect_valid;
  logic [ADDR_W-1:0]      redirect_pc;
  logic                   step;
  logic                   halted;
  logic [FETCH_CNT_W-1:0] fetch_count;

  modport master (
    input  start, imem_data, instr_ready, redirect_valid, redirect_pc, step,
    output imem_addr, imem_en, instr_valid, instr_out, instr_pc, halted, fetch_count
  );

  modport slave (
    output start, imem_data, instr_ready, redirect_valid, redirect_pc, step,
    input  imem_addr, imem_en, instr_valid, instr_out, instr_pc, halted, fetch_count
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, one memory read per instruction, valid/ready to decode,
// redirects from execute, stop on HALT. Macro SINGLE_STEP_EN enables single-step mode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 8,
  parameter int                 INSTR_W    = 8,
  parameter logic [ADDR_W-1:0]  START_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_INSTR_DEF)
) (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] v);
    return (v == '1) ? v : v + FETCH_CNT_W'(1);
  endfunction

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      pc, pc_nxt;
  logic [INSTR_W-1:0]     instr_p1;
  logic [ADDR_W-1:0]      instr_pc_p1;
  logic                   vld_p1;
  logic                   load_p1;
  logic                   count_inc;
  logic [FETCH_CNT_W-1:0] fetch_count;

`ifndef SINGLE_STEP_EN
  logic step_unused;
  assign step_unused = bus.step;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_p1   = 1'b0;
    count_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          pc_nxt    = START_PC;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.redirect_valid) begin
          pc_nxt = bus.redirect_pc;
        end else begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // A redirect discards the returning word even if it is the halt opcode.
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_pc;
          state_nxt = S_ISSUE;
        end else if (bus.imem_data == HALT_INSTR) begin
          state_nxt = S_HALTED;
        end else begin
          load_p1   = 1'b1;
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        count_inc = bus.instr_ready;
        if (bus.redirect_valid) begin
          pc_nxt    = bus.redirect_pc;
          state_nxt = S_ISSUE;
        end else if (bus.instr_ready) begin
          pc_nxt    = pc + ADDR_W'(1);
`ifdef SINGLE_STEP_EN
          state_nxt = S_STEP_WAIT;
`else
          state_nxt = S_ISSUE;
`endif
        end
      end
      S_HALTED: begin
        if (bus.start) begin
          pc_nxt    = START_PC;
          state_nxt = S_ISSUE;
        end
      end
`ifdef SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (bus.redirect_valid) pc_nxt = bus.redirect_pc;
        if (bus.step) state_nxt = S_ISSUE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= START_PC;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (count_inc) fetch_count <= sat_inc(fetch_count);
    end
  end

  // Stage p1: capture the registered memory word for presentation to decode
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
    end else if (load_p1) begin
      instr_p1    <= bus.imem_data;
      instr_pc_p1 <= pc;
    end
  end

  assign vld_p1 = (state == S_PRESENT);

  assign bus.imem_addr   = pc;
  assign bus.imem_en     = (state == S_ISSUE);
  assign bus.instr_valid = vld_p1;
  assign bus.instr_out   = instr_p1;
  assign bus.instr_pc    = instr_pc_p1;
  assign bus.halted      = (state == S_HALTED);
  assign bus.fetch_count = fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: program table, directed corner sequences, randomized run vs PC/count model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  fetch_sequencer #(
    .ADDR_W(8), .INSTR_W(8), .START_PC(8'h00), .HALT_INSTR(8'h30)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [256];
  always @(posedge clock) if (bus.imem_en) bus.imem_data <= mem[bus.imem_addr];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start          = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    bus.step           = 1'b0;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 256; i++) mem[i] = 8'h80 | 8'(i & 8'h7F);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_imem_en"},     bus.imem_en,     0);
    chk({tag, "_imem_addr"},   bus.imem_addr,   0);
    chk({tag, "_instr_valid"}, bus.instr_valid, 0);
    chk({tag, "_instr_out"},   bus.instr_out,   0);
    chk({tag, "_instr_pc"},    bus.instr_pc,    0);
    chk({tag, "_halted"},      bus.halted,      0);
    chk({tag, "_fetch_count"}, bus.fetch_count, 0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    bit found = 0;
    for (int i = 0; i < max; i++) begin
      if (bus.instr_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk({name, "_wait_valid"}, found, 1);
  endtask

  typedef struct {
    logic [7:0] m0, m1, m2, m3;
    int         cnt;
    logic [7:0] last_i;
    logic [7:0] last_pc;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [7:0] exp_pc;
    int         exp_cnt;
    bit         saw30;
    logic [7:0] lasti, lastpc;

    tbl[0] = '{m0: 8'hEF, m1: 8'h15, m2: 8'h30, m3: 8'h00, cnt: 2, last_i: 8'h15, last_pc: 8'h01};
    tbl[1] = '{m0: 8'h30, m1: 8'h11, m2: 8'h22, m3: 8'h33, cnt: 0, last_i: 8'h00, last_pc: 8'h00};
    tbl[2] = '{m0: 8'h01, m1: 8'h02, m2: 8'h03, m3: 8'h04, cnt: 4, last_i: 8'h04, last_pc: 8'h03};
    tbl[3] = '{m0: 8'hAA, m1: 8'h30, m2: 8'hBB, m3: 8'hCC, cnt: 1, last_i: 8'hAA, last_pc: 8'h00};

    idle_inputs();

    // Program table: run each short program to HALT with decode always ready
    for (int v = 0; v < 4; v++) begin
      fill_default();
      mem[0] = tbl[v].m0; mem[1] = tbl[v].m1; mem[2] = tbl[v].m2; mem[3] = tbl[v].m3;
      mem[4] = 8'h30;
      idle_inputs();
      do_reset(2);
      if (v == 0) check_reset_vals("reset");
      bus.instr_ready = 1'b1;
      pulse_start();
      saw30 = 0; lasti = 8'h00; lastpc = 8'h00;
      for (int k = 0; k < 60; k++) begin
        if (bus.halted) break;
        if (bus.instr_valid) begin
          if (bus.instr_out == 8'h30) saw30 = 1;
          lasti  = bus.instr_out;
          lastpc = bus.instr_pc;
        end
        tick();
      end
      chk($sformatf("tbl%0d_halted", v), bus.halted, 1);
      chk($sformatf("tbl%0d_count", v), bus.fetch_count, tbl[v].cnt);
      chk($sformatf("tbl%0d_no_halt_presented", v), saw30, 0);
      chk($sformatf("tbl%0d_valid_low", v), bus.instr_valid, 0);
      if (tbl[v].cnt > 0) begin
        chk($sformatf("tbl%0d_last_instr", v), lasti, tbl[v].last_i);
        chk($sformatf("tbl%0d_last_pc", v), lastpc, tbl[v].last_pc);
      end
    end

    // HALTED ignores redirect, restarts at START_PC on start
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h40;
    tick();
    bus.redirect_valid = 1'b0;
    chk("halt_redirect_halted", bus.halted, 1);
    chk("halt_redirect_no_en", bus.imem_en, 0);
    pulse_start();
    chk("restart_halted_clr", bus.halted, 0);
    chk("restart_en", bus.imem_en, 1);
    chk("restart_addr", bus.imem_addr, 8'h00);

    // Stall: decode holds ready low while 8'hEF is presented
    fill_default();
    mem[0] = 8'hEF;
    idle_inputs();
    do_reset(2);
    pulse_start();
    chk("stall_issue_en", bus.imem_en, 1);
    chk("stall_issue_valid", bus.instr_valid, 0);
    tick();
    chk("stall_capture_valid", bus.instr_valid, 0);
    tick();
    chk("stall_latency_valid", bus.instr_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_out_%0d", k), bus.instr_out, 8'hEF);
      chk($sformatf("stall_pc_%0d", k), bus.instr_pc, 8'h00);
      chk($sformatf("stall_cnt_%0d", k), bus.fetch_count, 0);
      tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("stall_accept_cnt", bus.fetch_count, 1);
    chk("stall_accept_valid", bus.instr_valid, 0);
    wait_valid("stall_next", 10);
    chk("stall_next_pc", bus.instr_pc, 8'h01);
    chk("stall_next_cnt", bus.fetch_count, 1);

    // Redirect coinciding with a handshake at pc 9
    fill_default();
    idle_inputs();
    do_reset(2);
    pulse_start();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h09;
    tick();
    bus.redirect_valid = 1'b0;
    wait_valid("redir9", 10);
    chk("redir9_pc", bus.instr_pc, 8'h09);
    chk("redir9_instr", bus.instr_out, 8'h89);
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h11;
    tick();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    chk("redir_hs_cnt", bus.fetch_count, 1);
    chk("redir_hs_valid", bus.instr_valid, 0);
    chk("redir_hs_addr", bus.imem_addr, 8'h11);
    wait_valid("redir11", 10);
    chk("redir11_pc", bus.instr_pc, 8'h11);
    chk("redir11_instr", bus.instr_out, 8'h91);

    // Redirect in CAPTURE while the memory returns the halt opcode
    fill_default();
    mem[0] = 8'h30;
    idle_inputs();
    do_reset(2);
    pulse_start();
    chk("caphalt_issue", bus.imem_en, 1);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h20;
    tick();
    bus.redirect_valid = 1'b0;
    chk("caphalt_not_halted", bus.halted, 0);
    chk("caphalt_reissue", bus.imem_en, 1);
    chk("caphalt_addr", bus.imem_addr, 8'h20);
    wait_valid("caphalt_resume", 10);
    chk("caphalt_resume_pc", bus.instr_pc, 8'h20);
    chk("caphalt_resume_instr", bus.instr_out, 8'hA0);

    // PC wrap at 8'hFF, then reset during PRESENT
    fill_default();
    idle_inputs();
    do_reset(2);
    pulse_start();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFF;
    tick();
    bus.redirect_valid = 1'b0;
    wait_valid("wrap", 10);
    chk("wrap_pc", bus.instr_pc, 8'hFF);
    chk("wrap_instr", bus.instr_out, 8'hFF);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("wrap_en", bus.imem_en, 1);
    chk("wrap_addr", bus.imem_addr, 8'h00);
    chk("wrap_cnt", bus.fetch_count, 1);
    wait_valid("wrap_next", 10);
    chk("wrap_next_pc", bus.instr_pc, 8'h00);
    reset = 1'b0;
    tick();
    check_reset_vals("midreset");
    reset = 1'b1;

    // Step input behaviour after an accepted instruction
    fill_default();
    idle_inputs();
    do_reset(2);
    bus.instr_ready = 1'b1;
    pulse_start();
    wait_valid("step", 10);
    tick();
    bus.instr_ready = 1'b0;
`ifdef SINGLE_STEP_EN
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("step_wait_no_en_%0d", k), bus.imem_en, 0);
      tick();
    end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("step_go_en", bus.imem_en, 1);
    chk("step_go_addr", bus.imem_addr, 8'h01);
`else
    chk("step_free_en", bus.imem_en, 1);
    chk("step_free_addr", bus.imem_addr, 8'h01);
    for (int k = 0; k < 3; k++) begin
      bus.step = ~bus.step;
      tick();
    end
    bus.step = 1'b0;
    chk("step_free_valid", bus.instr_valid, 1);
    chk("step_free_pc", bus.instr_pc, 8'h01);
`endif
    chk("step_cnt", bus.fetch_count, 1);

    // Randomized run against a PC / accept-count model
    for (int i = 0; i < 256; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if (r == 8'h30) r = 8'h31;
      mem[i] = r;
    end
    idle_inputs();
    do_reset(2);
    pulse_start();
    exp_pc  = 8'h00;
    exp_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      bit hs;
      chk("rand_count", bus.fetch_count, exp_cnt);
      if (bus.instr_valid) begin
        chk("rand_pc", bus.instr_pc, exp_pc);
        chk("rand_instr", bus.instr_out, mem[exp_pc]);
      end
      bus.instr_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      bus.redirect_pc    = 8'($urandom);
      bus.step           = 1'($urandom);
      hs = bus.instr_valid && bus.instr_ready;
      if (bus.redirect_valid) exp_pc = bus.redirect_pc;
      else if (hs) exp_pc = exp_pc + 8'd1;
      if (hs) exp_cnt++;
      tick();
    end
    chk("rand_progress", (exp_cnt > 200), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
